// File: rtl/bsl_iter.sv
// Multi-cycle logarithmic left barrel shifter/rotator: one shift-by-2^k stage per clock,
// with valid/ready handshakes on both sides. The datapath is 32 bits wide by default.
module bsl_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [SHW-1:0]   sel,
    input  logic             rotate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int STW = (SHW > 1) ? $clog2(SHW) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [SHW-1:0]   amt_reg;
    logic             rot_reg;
    logic [STW-1:0]   stage_reg;
    logic [WIDTH-1:0] out_reg;
    logic             zero_reg;
    logic             out_valid_reg;
    logic             in_ready_reg;

    logic [WIDTH-1:0] stage_val [SHW];
    logic [WIDTH-1:0] data_next;
    logic             last_stage;

    // Every stage's candidate is precomputed; the stage counter picks which one is applied.
    for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        assign stage_val[gi] = rot_reg
            ? {data_reg[WIDTH-SH-1:0], data_reg[WIDTH-1:WIDTH-SH]}
            : {data_reg[WIDTH-SH-1:0], {SH{1'b0}}};
    end

    always_comb begin
        data_next  = data_reg;
        for (int i = 0; i < SHW; i++) begin
            if (stage_reg == STW'(i) && amt_reg[i]) begin
                data_next = stage_val[i];
            end
        end
        last_stage = (stage_reg == STW'(SHW - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            amt_reg       <= '0;
            rot_reg       <= 1'b0;
            stage_reg     <= '0;
            out_reg       <= '0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg     <= in;
                        amt_reg      <= sel;
                        rot_reg      <= rotate;
                        stage_reg    <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_reg  <= data_next;
                    stage_reg <= stage_reg + STW'(1);
                    // Fixed latency: all SHW stages run even when their amount bit is 0.
                    if (last_stage) begin
                        stage_reg     <= '0;
                        out_reg       <= data_next;
                        zero_reg      <= (data_next == '0);
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out       = out_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_bsl_iter.sv
// Directed and randomised checks of bsl_iter: results, fixed latency, backpressure,
// mid-operation reset and one-delivery-per-accept accounting.
module tb_bsl_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] din = '0;
    logic [4:0]  sel = '0;
    logic        rotate = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] dout;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;
    int accepts  = 0;
    int delivered = 0;
    int aborted  = 0;

    bsl_iter #(.WIDTH(32), .SHW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .sel       (sel),
        .rotate    (rotate),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            if (in_valid && in_ready)   accepts   <= accepts + 1;
            if (out_valid && out_ready) delivered <= delivered + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shl(input logic [31:0] a, input int n, input logic r);
        logic [31:0] v;
        if (n == 0) return a;
        v = a << n;
        if (r) v = v | (a >> (32 - n));
        return v;
    endfunction

    task automatic wait_ready();
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    // Issue one op, check latency, result, stall behaviour and the closing handshake.
    task automatic run_op(input logic [31:0] a, input logic [4:0] n, input logic r,
                          input logic [31:0] exp, input int stall, input bit verbose);
        int lat = 0;
        wait_ready();
        din = a; sel = n; rotate = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; din = 32'hDEAD_BEEF; sel = 5'd7; rotate = ~r;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk("latency", lat, 32'd5);
        chk("out", dout, exp);
        chk("zero", {31'b0, zero}, {31'b0, exp == 32'd0});
        chk("in_ready_done", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            if (i == 0) begin
                in_valid = 1'b1; din = ~a; sel = n + 5'd1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_out", dout, exp);
            chk("stall_zero", {31'b0, zero}, {31'b0, exp == 32'd0});
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", {31'b0, out_valid}, 32'd0);
        chk("post_in_ready", {31'b0, in_ready}, 32'd1);
        if (verbose)
            $display("op in=%h sel=%0d rot=%0d -> out=%h zero=%0d lat=%0d stall=%0d",
                     a, n, r, exp, exp == 32'd0, lat, stall);
    endtask

    initial begin
        int seen;
        logic [31:0] ra;
        logic [4:0]  rn;
        logic        rr;

        #12;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out", dout, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        run_op(32'hF2F2_F2F2, 5'd4,  1'b0, 32'h2F2F_2F20, 0, 1'b1);
        run_op(32'hF2F2_F2F2, 5'd4,  1'b1, 32'h2F2F_2F2F, 0, 1'b1);
        run_op(32'h2F2F_2F2F, 5'd4,  1'b1, 32'hF2F2_F2F2, 0, 1'b1);
        run_op(32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 0, 1'b1);
        run_op(32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003, 0, 1'b1);
        run_op(32'h8000_0000, 5'd1,  1'b0, 32'h0000_0000, 0, 1'b1);
        run_op(32'hA5A5_0FF0, 5'd0,  1'b1, 32'hA5A5_0FF0, 0, 1'b1);
        run_op(32'hA5A5_0FF0, 5'd0,  1'b0, 32'hA5A5_0FF0, 0, 1'b1);
        run_op(32'h1234_5678, 5'd8,  1'b0, 32'h3456_7800, 10, 1'b1);
        run_op(32'h0000_00FF, 5'd28, 1'b1, 32'hF000_000F, 0, 1'b1);

        // Reset asynchronously two cycles into SHIFT.
        wait_ready();
        din = 32'hCAFE_F00D; sel = 5'd3; rotate = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
        aborted++;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_out", dout, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk); @(negedge clk); reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("mid_rst_no_result", seen, 32'd0);
        $display("reset mid-SHIFT: abandoned, spurious results=%0d", seen);
        run_op(32'h1234_5678, 5'd8, 1'b1, 32'h3456_7812, 0, 1'b1);

        for (int t = 0; t < 1000; t++) begin
            ra = $urandom;
            rn = 5'($urandom_range(0, 31));
            rr = 1'($urandom_range(0, 1));
            if (t % 50 == 0) ra = 32'h0;
            run_op(ra, rn, rr, ref_shl(ra, int'(rn), rr), $urandom_range(0, 3), t < 5);
        end

        @(posedge clk); #1;
        chk("one_result_per_accept", delivered, accepts - aborted);
        $display("accounting: accepts=%0d aborted=%0d delivered=%0d", accepts, aborted, delivered);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
